mbinit_sb_tx_arbiter: RTL and testbench

- Shares the single sideband TX serializer between the two MBINIT sub-state requesters: the module (initiator, sends *_req messages) and the module partner (responder, sends *_resp messages).
- Buffers one message per requester and arbitrates round-robin.
- Issues each message to the serializer and tracks the serializer busy handshake.
- Returns per-requester busy and done indications, which replace the raw serializer busy and falling-edge signals the requesters use today.

---
 rtl/mbinit_sb_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_mbinit_sb_tx_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mbinit_sb_tx_arbiter.sv
// Sideband TX arbiter for MBINIT: one message slot per requester (module/partner),
// round-robin issue to the shared serializer, per-requester busy/done back to the requesters.
module mbinit_sb_tx_arbiter #(
   parameter int MSG_W   = 4,
   parameter int DATA_W  = 1,
   parameter int RISE_TO = 8
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              i_enable,
   input  logic              i_mod_valid,
   input  logic [MSG_W-1:0]  i_mod_msg,
   input  logic [DATA_W-1:0] i_mod_data,
   input  logic              i_ptr_valid,
   input  logic [MSG_W-1:0]  i_ptr_msg,
   input  logic [DATA_W-1:0] i_ptr_data,
   input  logic              i_sb_busy,
   output logic              o_sb_valid,
   output logic [MSG_W-1:0]  o_sb_msg,
   output logic [DATA_W-1:0] o_sb_data,
   output logic              o_mod_busy,
   output logic              o_mod_done,
   output logic              o_ptr_busy,
   output logic              o_ptr_done,
   output logic              o_overflow
);

   // state     | meaning
   // IDLE      | waiting for a full slot and an idle serializer
   // ISSUE     | one-cycle issue strobe of the owner slot
   // WAIT_RISE | waiting for serializer busy to rise (bounded by RISE_TO)
   // WAIT_FALL | serializer busy, waiting for it to drop
   // DONE      | one-cycle done pulse to owner, owner slot freed
   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_RISE, S_WAIT_FALL, S_DONE
   } state_t;

   localparam int CNT_W = (RISE_TO > 1) ? $clog2(RISE_TO) : 1;
   localparam logic OWN_MOD = 1'b0;
   localparam logic OWN_PTR = 1'b1;

   state_t             state, state_nxt;
   logic               owner, owner_nxt;
   logic               last_grant, last_grant_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               mod_full, ptr_full;
   logic [MSG_W-1:0]   mod_msg, ptr_msg;
   logic [DATA_W-1:0]  mod_data, ptr_data;
   logic               overflow;
   logic               mod_done_now, ptr_done_now;

   assign mod_done_now = (state == S_DONE) && (owner == OWN_MOD);
   assign ptr_done_now = (state == S_DONE) && (owner == OWN_PTR);

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_grant_nxt = last_grant;
      cnt_nxt        = cnt;
      case (state)
         S_IDLE: begin
            if (!i_sb_busy && (mod_full || ptr_full)) begin
               // On a tie the requester that did not win last time gets the serializer
               owner_nxt      = (mod_full && ptr_full) ? ~last_grant : ptr_full;
               last_grant_nxt = owner_nxt;
               state_nxt      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_nxt   = '0;
            state_nxt = S_WAIT_RISE;
         end
         S_WAIT_RISE: begin
            if (i_sb_busy)
               state_nxt = S_WAIT_FALL;
            else if (cnt == CNT_W'(RISE_TO - 1))
               state_nxt = S_DONE;
            else
               cnt_nxt = cnt + CNT_W'(1);
         end
         S_WAIT_FALL: begin
            if (!i_sb_busy)
               state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state      <= S_IDLE;
         owner      <= OWN_MOD;
         last_grant <= OWN_PTR;
         cnt        <= '0;
         mod_full   <= 1'b0;
         ptr_full   <= 1'b0;
         mod_msg    <= '0;
         ptr_msg    <= '0;
         mod_data   <= '0;
         ptr_data   <= '0;
         overflow   <= 1'b0;
      end else if (!i_enable) begin
         // Flush keeps last_grant so fairness survives an MBINIT restart
         state    <= S_IDLE;
         owner    <= OWN_MOD;
         cnt      <= '0;
         mod_full <= 1'b0;
         ptr_full <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_grant <= last_grant_nxt;
         cnt        <= cnt_nxt;

         if (i_mod_valid && (!mod_full || mod_done_now)) begin
            mod_full <= 1'b1;
            mod_msg  <= i_mod_msg;
            mod_data <= i_mod_data;
         end else begin
            if (mod_done_now) mod_full <= 1'b0;
            if (i_mod_valid)  overflow <= 1'b1;
         end

         if (i_ptr_valid && (!ptr_full || ptr_done_now)) begin
            ptr_full <= 1'b1;
            ptr_msg  <= i_ptr_msg;
            ptr_data <= i_ptr_data;
         end else begin
            if (ptr_done_now) ptr_full <= 1'b0;
            if (i_ptr_valid)  overflow <= 1'b1;
         end
      end
   end

   assign o_sb_valid = (state == S_ISSUE);
   assign o_sb_msg   = o_sb_valid ? ((owner == OWN_PTR) ? ptr_msg : mod_msg) : '0;
   assign o_sb_data  = o_sb_valid ? ((owner == OWN_PTR) ? ptr_data : mod_data) : '0;
   assign o_mod_busy = mod_full && !mod_done_now;
   assign o_mod_done = mod_done_now;
   assign o_ptr_busy = ptr_full && !ptr_done_now;
   assign o_ptr_done = ptr_done_now;
   assign o_overflow = overflow;

endmodule

// File: tb/tb_mbinit_sb_tx_arbiter.sv
// Directed bench for mbinit_sb_tx_arbiter; every cycle of each scenario is checked
// against hand-derived expected timelines.
module tb_mbinit_sb_tx_arbiter;

   logic       CLK = 1'b0;
   logic       rst;
   logic       i_enable;
   logic       i_mod_valid;
   logic [3:0] i_mod_msg;
   logic [0:0] i_mod_data;
   logic       i_ptr_valid;
   logic [3:0] i_ptr_msg;
   logic [0:0] i_ptr_data;
   logic       i_sb_busy;
   logic       o_sb_valid;
   logic [3:0] o_sb_msg;
   logic [0:0] o_sb_data;
   logic       o_mod_busy, o_mod_done, o_ptr_busy, o_ptr_done, o_overflow;

   logic       auto_ser;
   logic       busy_man;
   logic [1:0] ser_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   mbinit_sb_tx_arbiter #(.MSG_W(4), .DATA_W(1), .RISE_TO(8)) dut (
      .CLK(CLK), .rst(rst), .i_enable(i_enable),
      .i_mod_valid(i_mod_valid), .i_mod_msg(i_mod_msg), .i_mod_data(i_mod_data),
      .i_ptr_valid(i_ptr_valid), .i_ptr_msg(i_ptr_msg), .i_ptr_data(i_ptr_data),
      .i_sb_busy(i_sb_busy),
      .o_sb_valid(o_sb_valid), .o_sb_msg(o_sb_msg), .o_sb_data(o_sb_data),
      .o_mod_busy(o_mod_busy), .o_mod_done(o_mod_done),
      .o_ptr_busy(o_ptr_busy), .o_ptr_done(o_ptr_done),
      .o_overflow(o_overflow)
   );

   // Serializer stand-in: busy for two cycles starting the cycle after an issue
   always @(posedge CLK) begin
      if (rst)             ser_cnt <= 2'd0;
      else if (o_sb_valid) ser_cnt <= 2'd2;
      else if (ser_cnt != 2'd0) ser_cnt <= ser_cnt - 2'd1;
   end
   assign i_sb_busy = auto_ser ? (ser_cnt != 2'd0) : busy_man;

   task automatic check(input string tag, input int cyc, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
      end
   endtask

   task automatic expect_outs(input string tag, input int c, input logic v, input logic [3:0] m,
                              input logic d, input logic mb, input logic md, input logic pb,
                              input logic pd, input logic ov);
      check({tag, ".sb_valid"}, c, 32'(o_sb_valid), 32'(v));
      check({tag, ".sb_msg"},   c, 32'(o_sb_msg),   32'(m));
      check({tag, ".sb_data"},  c, 32'(o_sb_data),  32'(d));
      check({tag, ".mod_busy"}, c, 32'(o_mod_busy), 32'(mb));
      check({tag, ".mod_done"}, c, 32'(o_mod_done), 32'(md));
      check({tag, ".ptr_busy"}, c, 32'(o_ptr_busy), 32'(pb));
      check({tag, ".ptr_done"}, c, 32'(o_ptr_done), 32'(pd));
      check({tag, ".overflow"}, c, 32'(o_overflow), 32'(ov));
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      i_enable    = 1'b1;
      i_mod_valid = 1'b0;
      i_mod_msg   = 4'h0;
      i_mod_data  = 1'b0;
      i_ptr_valid = 1'b0;
      i_ptr_msg   = 4'h0;
      i_ptr_data  = 1'b0;
      busy_man    = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      expect_outs({tag, ".rst"}, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      auto_ser = 1'b0;
      clear_inputs();

      // T1: single module message, serializer busy 13..15
      do_reset("t1");
      for (int c = 0; c <= 20; c++) begin
         clear_inputs();
         i_mod_valid = (c == 10);
         i_mod_msg   = 4'b0001;
         busy_man    = (c >= 13 && c <= 15);
         expect_outs("t1", c, c == 12, (c == 12) ? 4'b0001 : 4'h0, 0,
                     c >= 11 && c <= 16, c == 17, 0, 0, 0);
         step();
      end

      // T2: ties and round-robin alternation with a responsive serializer
      auto_ser = 1'b1;
      do_reset("t2");
      for (int c = 0; c <= 52; c++) begin
         logic       ev;
         logic [3:0] em;
         logic       ed;
         clear_inputs();
         i_mod_valid = (c inside {2, 16, 30, 38});
         case (c)
            2:  i_mod_msg = 4'h3;
            16: i_mod_msg = 4'h5;
            30: i_mod_msg = 4'h8;
            38: i_mod_msg = 4'h9;
            default: i_mod_msg = 4'h0;
         endcase
         i_ptr_valid = (c inside {2, 16, 38});
         case (c)
            2:  begin i_ptr_msg = 4'h4; i_ptr_data = 1'b1; end
            16: i_ptr_msg = 4'h6;
            38: i_ptr_msg = 4'h7;
            default: i_ptr_msg = 4'h0;
         endcase
         ev = 1'b1; ed = 1'b0;
         case (c)
            4:  em = 4'h3;
            10: begin em = 4'h4; ed = 1'b1; end
            18: em = 4'h5;
            24: em = 4'h6;
            32: em = 4'h8;
            40: em = 4'h7;
            46: em = 4'h9;
            default: begin ev = 1'b0; em = 4'h0; end
         endcase
         expect_outs("t2", c, ev, em, ed,
                     c inside {[3:7], [17:21], [31:35], [39:49]},
                     c inside {8, 22, 36, 50},
                     c inside {[3:13], [17:27], [39:43]},
                     c inside {14, 28, 44}, 0);
         step();
      end

      // T3: serializer never raises busy, rise timeout completes the message
      auto_ser = 1'b0;
      do_reset("t3");
      for (int c = 0; c <= 15; c++) begin
         clear_inputs();
         i_mod_valid = (c == 2);
         i_mod_msg   = 4'h2;
         expect_outs("t3", c, c == 4, (c == 4) ? 4'h2 : 4'h0, 0,
                     c >= 3 && c <= 12, c == 13, 0, 0, 0);
         step();
      end

      // T4: overflow on full slot, reload coincident with done accepted
      auto_ser = 1'b1;
      do_reset("t4");
      for (int c = 0; c <= 16; c++) begin
         clear_inputs();
         i_ptr_valid = (c inside {2, 3, 8});
         case (c)
            2: i_ptr_msg = 4'h5;
            3: i_ptr_msg = 4'b0110;
            8: i_ptr_msg = 4'h7;
            default: i_ptr_msg = 4'h0;
         endcase
         expect_outs("t4", c, c inside {4, 10},
                     (c == 4) ? 4'h5 : ((c == 10) ? 4'h7 : 4'h0), 0,
                     0, 0, c inside {[3:7], [9:13]}, c inside {8, 14}, c >= 4);
         step();
      end

      // T5: enable dropped during WAIT_FALL, then normal service after re-enable
      auto_ser = 1'b0;
      do_reset("t5");
      for (int c = 0; c <= 24; c++) begin
         clear_inputs();
         i_enable    = !(c >= 8 && c <= 10);
         i_mod_valid = (c inside {2, 5, 15});
         case (c)
            2:  i_mod_msg = 4'h1;
            5:  i_mod_msg = 4'h2;
            15: i_mod_msg = 4'hA;
            default: i_mod_msg = 4'h0;
         endcase
         i_ptr_valid = (c == 9);
         i_ptr_msg   = 4'h3;
         busy_man    = (c >= 5 && c <= 12) || (c >= 18 && c <= 19);
         expect_outs("t5", c, c inside {4, 17},
                     (c == 4) ? 4'h1 : ((c == 17) ? 4'hA : 4'h0), 0,
                     c inside {[3:8], [16:20]}, c == 21, 0, 0, c inside {[6:8]});
         step();
      end

      // T6: external serializer user holds busy for 20 cycles
      do_reset("t6");
      for (int c = 0; c <= 32; c++) begin
         clear_inputs();
         i_mod_valid = (c == 2);
         i_mod_msg   = 4'hC;
         busy_man    = (c <= 19);
         expect_outs("t6", c, c == 21, (c == 21) ? 4'hC : 4'h0, 0,
                     c >= 3 && c <= 29, c == 30, 0, 0, 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
